// File: rtl/valrdy_demux_buf.sv
// One-to-N val/rdy demultiplexer with a one-entry registered slot per output port.
// Optional feature: define VALRDY_DEMUX_BUF_ERR_EN to accept-and-drop out-of-range selects and raise a sticky err.
module valrdy_demux_buf #(
  parameter  int p_nbits   = 32,
  parameter  int p_nports  = 4,
  localparam int c_selbits = (p_nports > 1) ? $clog2(p_nports) : 1
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          in_val,
  output logic                          in_rdy,
  input  logic [p_nbits-1:0]            in_msg,
  input  logic [c_selbits-1:0]          in_sel,
  output logic [p_nports-1:0]           out_val,
  input  logic [p_nports-1:0]           out_rdy,
  output logic [p_nports*p_nbits-1:0]   out_msg
`ifdef VALRDY_DEMUX_BUF_ERR_EN
  ,
  output logic                          err
`endif
);

  logic [p_nports-1:0] full;
  logic [p_nbits-1:0]  data [p_nports];

  logic [p_nports-1:0] sel_hit;
  logic [p_nports-1:0] enq;
  logic [p_nports-1:0] deq;
  logic                sel_ok;
  logic                tgt_free;

  // Decode the select by comparison so an out-of-range index never addresses the slot arrays.
  // NOTE: every always_comb output gets a default before any branch, so no latch can be inferred.
  always_comb begin
    sel_hit  = '0;
    tgt_free = 1'b0;
    for (int i = 0; i < p_nports; i++) begin
      if (in_sel == c_selbits'(i)) begin
        sel_hit[i] = 1'b1;
        tgt_free   = !full[i] || out_rdy[i];
      end
    end
  end

  assign sel_ok = |sel_hit;

`ifdef VALRDY_DEMUX_BUF_ERR_EN
  // Out-of-range selects are swallowed immediately so the producer never stalls on them.
  assign in_rdy = !reset && (!sel_ok || tgt_free);
`else
  assign in_rdy = !reset && sel_ok && tgt_free;
`endif

  assign enq = {p_nports{in_val && in_rdy}} & sel_hit;
  assign deq = full & out_rdy;

  // NOTE: the payload slots are reset too, so out_msg is defined from the first cycle after reset.
  // NOTE: sequential state uses non-blocking assignments so every slot samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      full <= '0;
      for (int i = 0; i < p_nports; i++) begin
        data[i] <= '0;
      end
    end else begin
      for (int i = 0; i < p_nports; i++) begin
        if (enq[i]) begin
          full[i] <= 1'b1;
          data[i] <= in_msg;
        end else if (deq[i]) begin
          full[i] <= 1'b0;
        end
      end
    end
  end

`ifdef VALRDY_DEMUX_BUF_ERR_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      err <= 1'b0;
    end else if (in_val && in_rdy && !sel_ok) begin
      err <= 1'b1;
    end
  end
`endif

  assign out_val = full;

  for (genvar g = 0; g < p_nports; g++) begin : g_out
    assign out_msg[g*p_nbits +: p_nbits] = data[g];
  end

endmodule

// File: tb/tb_valrdy_demux_buf.sv
// Bench for valrdy_demux_buf: a 4-port and a 3-port instance share one stimulus stream and
// are compared every cycle against a queue-based reference of the demux rules.
module tb_valrdy_demux_buf;

  logic         clk = 1'b0;
  logic         reset;
  logic         in_val;
  logic [1:0]   in_sel;
  logic [31:0]  in_msg;
  logic [3:0]   out_rdy;

  logic         rdy4, rdy3;
  logic [3:0]   val4;
  logic [2:0]   val3;
  logic [127:0] msg4;
  logic [95:0]  msg3;
`ifdef VALRDY_DEMUX_BUF_ERR_EN
  logic         err4, err3;
  localparam bit c_err_en = 1'b1;
`else
  localparam bit c_err_en = 1'b0;
`endif

  always #5 clk = ~clk;

  valrdy_demux_buf #(.p_nbits(32), .p_nports(4)) dut4 (
    .clk     (clk),
    .reset   (reset),
    .in_val  (in_val),
    .in_rdy  (rdy4),
    .in_msg  (in_msg),
    .in_sel  (in_sel),
    .out_val (val4),
    .out_rdy (out_rdy),
    .out_msg (msg4)
`ifdef VALRDY_DEMUX_BUF_ERR_EN
    ,
    .err     (err4)
`endif
  );

  valrdy_demux_buf #(.p_nbits(32), .p_nports(3)) dut3 (
    .clk     (clk),
    .reset   (reset),
    .in_val  (in_val),
    .in_rdy  (rdy3),
    .in_msg  (in_msg),
    .in_sel  (in_sel),
    .out_val (val3),
    .out_rdy (out_rdy[2:0]),
    .out_msg (msg3)
`ifdef VALRDY_DEMUX_BUF_ERR_EN
    ,
    .err     (err3)
`endif
  );

  // Reference: per instance k, port i owns queue mq[k*8+i] of accepted-but-undelivered messages,
  // and last[k*8+i] is the most recently accepted payload (what the output slot shows).
  int          np [2] = '{4, 3};
  logic [31:0] mq   [16][$];
  logic [31:0] last [16];
  logic        merr [2];

  int n_vec = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic logic exp_rdy(int k);
    if (reset) return 1'b0;
    if (int'(in_sel) >= np[k]) return c_err_en;
    return (mq[k*8 + int'(in_sel)].size() == 0) || out_rdy[in_sel];
  endfunction

  function automatic logic [127:0] exp_val(int k);
    logic [127:0] r = '0;
    for (int i = 0; i < np[k]; i++) r[i] = (mq[k*8+i].size() != 0);
    return r;
  endfunction

  function automatic logic [127:0] exp_msg(int k);
    logic [127:0] r = '0;
    for (int i = 0; i < np[k]; i++) r[i*32 +: 32] = last[k*8+i];
    return r;
  endfunction

  task automatic model_reset();
    for (int j = 0; j < 16; j++) begin
      mq[j].delete();
      last[j] = '0;
    end
    merr[0] = 1'b0;
    merr[1] = 1'b0;
  endtask

  // One clock: inputs are already stable (set after the falling edge); check in_rdy,
  // advance the reference across the rising edge, then check the registered outputs.
  task automatic step();
    logic r [2];
    #1;
    r[0] = exp_rdy(0);
    r[1] = exp_rdy(1);
    check("in_rdy_p4", 128'(rdy4), 128'(r[0]));
    check("in_rdy_p3", 128'(rdy3), 128'(r[1]));
    @(posedge clk);
    #1;
    if (reset) begin
      model_reset();
    end else begin
      for (int k = 0; k < 2; k++) begin
        for (int i = 0; i < np[k]; i++) begin
          if (mq[k*8+i].size() != 0 && out_rdy[i]) void'(mq[k*8+i].pop_front());
        end
        if (in_val && r[k]) begin
          if (int'(in_sel) < np[k]) begin
            mq[k*8 + int'(in_sel)].push_back(in_msg);
            last[k*8 + int'(in_sel)] = in_msg;
          end else begin
            merr[k] = 1'b1;
          end
        end
      end
    end
    check("out_val_p4", 128'(val4), exp_val(0));
    check("out_msg_p4", 128'(msg4), exp_msg(0));
    check("out_val_p3", 128'(val3), exp_val(1));
    check("out_msg_p3", 128'(msg3), exp_msg(1));
`ifdef VALRDY_DEMUX_BUF_ERR_EN
    check("err_p4", 128'(err4), 128'(merr[0]));
    check("err_p3", 128'(err3), 128'(merr[1]));
`endif
    @(negedge clk);
  endtask

  task automatic send(input logic [1:0] sel, input logic [31:0] msg);
    in_val = 1'b1;
    in_sel = sel;
    in_msg = msg;
    step();
  endtask

  initial begin
    model_reset();
    reset   = 1'b1;
    in_val  = 1'b1;
    in_sel  = 2'd0;
    in_msg  = 32'hAAAA_AAAA;
    out_rdy = 4'h0;
    @(negedge clk);

    // Reset held two cycles with a valid message pending.
    step();
    step();
    reset  = 1'b0;
    in_val = 1'b0;
    step();

    // Basic routing to every port.
    out_rdy = 4'hF;
    for (int s = 0; s < 4; s++) send(2'(s), 32'(8'h11 * (s + 1)));
    in_val = 1'b0;
    step();

    // Back-to-back traffic to a single port.
    for (int m = 0; m < 8; m++) send(2'd2, 32'(m));
    in_val = 1'b0;
    step();

    // Backpressure on port 1; the next message waits at the head of the line.
    out_rdy = 4'b1101;
    send(2'd1, 32'hA1);
    send(2'd1, 32'hB1);
    step();
    step();
    out_rdy = 4'hF;
    step();
    send(2'd3, 32'hC3);
    in_val = 1'b0;
    step();
    step();

    // Reset while ports 0 and 3 hold undelivered messages.
    out_rdy = 4'h0;
    send(2'd0, 32'h50);
    send(2'd3, 32'h53);
    in_val = 1'b0;
    reset  = 1'b1;
    step();
    reset   = 1'b0;
    out_rdy = 4'hF;
    step();
    step();

    // Select 3: a real port for the 4-port instance, out of range for the 3-port one.
    send(2'd3, 32'hDEAD);
    step();
    in_val = 1'b0;
    step();
    step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    step();

    // Randomized traffic with occasional reset and undefined payload while idle.
    for (int n = 0; n < 600; n++) begin
      reset   = ($urandom_range(0, 99) == 0);
      in_val  = ($urandom_range(0, 3) != 0);
      in_sel  = 2'($urandom_range(0, 3));
      in_msg  = (in_val || $urandom_range(0, 3) != 0) ? $urandom : 32'hx;
      out_rdy = 4'($urandom);
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
